// File: rtl/issue_buffer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// issue_buffer_pkg : decoded-entry field layout and hazard helper
// Rev 1.0
// ----------------------------------------------------------------------------
package issue_buffer_pkg;

  localparam int REG_WD        = 5;
  localparam int DS_DEST       = 0;
  localparam int DS_GR_WE      = 5;
  localparam int DS_RS1        = 6;
  localparam int DS_RS2        = 11;
  localparam int DS_IS_BR      = 16;
  localparam int DS_IS_CPLX    = 17;
  localparam int DS_IS_SERIAL  = 18;
  localparam int DS_TAG        = 19;
  localparam int TAG_WD        = 13;
  localparam int DECODE_BUS_WD = DS_TAG + TAG_WD;

  // Widths of the original dual-issue front.
  localparam int SINGLE = 1;
  localparam int DUAL   = 2;

  typedef logic [REG_WD-1:0] reg_idx_t;

  // True when slot k reads or rewrites the register written by earlier slot j.
  function automatic logic reg_conflict(reg_idx_t dest_j, reg_idx_t dest_k,
                                        reg_idx_t rs1_k, reg_idx_t rs2_k);
    return ((rs1_k != '0) && (rs1_k == dest_j)) ||
           ((rs2_k != '0) && (rs2_k == dest_j)) ||
           (dest_k == dest_j);
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_buffer_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// issue_buffer_if : decode-side write port and issue-side group port
// Rev 1.0
// ----------------------------------------------------------------------------
interface issue_buffer_if
  import issue_buffer_pkg::*;
#(
  parameter int W      = DUAL,
  parameter int BUS_WD = DECODE_BUS_WD
);
  logic [W-1:0]             in_valid;
  logic [W*BUS_WD-1:0]      in_bus;
  logic                     in_allowin;
  logic                     issue_allowin;
  logic [W-1:0]             issue_valid;
  logic [W*BUS_WD-1:0]      issue_bus;
  logic                     issue_int;
  logic [$clog2(W+1)-1:0]   issue_cnt;

  modport master (
    output in_valid, in_bus, issue_allowin,
    input  in_allowin, issue_valid, issue_bus, issue_int, issue_cnt
  );

  modport slave (
    input  in_valid, in_bus, issue_allowin,
    output in_allowin, issue_valid, issue_bus, issue_int, issue_cnt
  );
endinterface
`default_nettype wire

// File: rtl/issue_buffer_group_check.sv
`default_nettype none
// ----------------------------------------------------------------------------
// issue_group_check : length of the in-order issue group formed at the head
// Rev 1.0
// ----------------------------------------------------------------------------
module issue_group_check
  import issue_buffer_pkg::*;
#(
  parameter int W      = DUAL,
  parameter int BUS_WD = DECODE_BUS_WD
) (
  input  logic [W*BUS_WD-1:0]    entries,
  input  logic [$clog2(W+1)-1:0] avail,
  output logic [$clog2(W+1)-1:0] len
);

  localparam int c_GW = $clog2(W+1);

  logic w_ok;
  logic w_stop;
  logic w_cplx_seen;
  logic w_unused;

  assign w_unused = ^entries;

  always_comb begin
    len         = '0;
    w_ok        = 1'b0;
    w_stop      = 1'b0;
    w_cplx_seen = 1'b0;
    for (int k = 0; k < W; k++) begin
      w_ok = !w_stop && (k < int'(avail));
      if (k >= SINGLE && entries[DS_IS_SERIAL])
        w_ok = 1'b0;
      // A branch only goes out together with its delay slot.
      if (entries[k*BUS_WD + DS_IS_BR] && ((k + 1 >= W) || (k + 1 >= int'(avail))))
        w_ok = 1'b0;
      if (entries[k*BUS_WD + DS_IS_CPLX] && w_cplx_seen)
        w_ok = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (entries[j*BUS_WD + DS_GR_WE] &&
            reg_conflict(entries[j*BUS_WD + DS_DEST +: REG_WD],
                         entries[k*BUS_WD + DS_DEST +: REG_WD],
                         entries[k*BUS_WD + DS_RS1  +: REG_WD],
                         entries[k*BUS_WD + DS_RS2  +: REG_WD]))
          w_ok = 1'b0;
      end
      if (w_ok) begin
        len         = c_GW'(k + 1);
        w_cplx_seen = w_cplx_seen | entries[k*BUS_WD + DS_IS_CPLX];
      end else begin
        w_stop = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/issue_buffer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// issue_buffer : D-entry circular decode buffer issuing in-order W-wide groups
// Rev 1.0
// ----------------------------------------------------------------------------
module issue_buffer
  import issue_buffer_pkg::*;
#(
  parameter int W      = DUAL,
  parameter int D      = 8,
  parameter int BUS_WD = DECODE_BUS_WD,
  parameter int CNT_WD = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    has_int,
  issue_buffer_if.slave           ib,
  output logic [(W+1)*CNT_WD-1:0] perf_grp_cnt,
  output logic [CNT_WD-1:0]       perf_stall_cnt
);

  localparam int c_PW = $clog2(D);
  localparam int c_GW = $clog2(W+1);

  logic [BUS_WD-1:0]   r_mem [D];
  logic [c_PW-1:0]     r_head;
  logic [c_PW-1:0]     r_tail;
  logic [c_PW:0]       r_count;
  logic [CNT_WD-1:0]   r_grp_cnt [W+1];
  logic [CNT_WD-1:0]   r_stall_cnt;

  logic [W*BUS_WD-1:0] w_head_bus;
  logic [c_GW-1:0]     w_avail;
  logic [c_GW-1:0]     w_grp_len;
  logic [c_GW-1:0]     w_iss_num;
  logic [c_GW-1:0]     w_wr_num;
  logic [c_GW-1:0]     w_wr_add;
  logic [W-1:0]        w_valid;
  logic                w_allowin;
  logic                w_wr_en;

  // Allow-in looks only at the registered occupancy.
  assign w_allowin = (r_count <= (c_PW+1)'(D - W));
  assign w_wr_en   = w_allowin && (|ib.in_valid) && !flush;
  assign w_wr_add  = w_wr_en ? w_wr_num : '0;
  assign w_avail   = (r_count >= (c_PW+1)'(W)) ? c_GW'(W) : c_GW'(r_count);
  assign w_iss_num = (ib.issue_allowin && !flush) ? w_grp_len : '0;

  always_comb begin
    w_wr_num = '0;
    for (int k = 0; k < W; k++)
      w_wr_num = w_wr_num + c_GW'(ib.in_valid[k]);
  end

  always_comb begin
    w_head_bus = '0;
    w_valid    = '0;
    for (int k = 0; k < W; k++) begin
      w_head_bus[k*BUS_WD +: BUS_WD] = r_mem[r_head + c_PW'(k)];
      w_valid[k]                     = (k < int'(w_iss_num));
    end
  end

  issue_group_check #(
    .W      (W),
    .BUS_WD (BUS_WD)
  ) u_group_check (
    .entries (w_head_bus),
    .avail   (w_avail),
    .len     (w_grp_len)
  );

  assign ib.in_allowin  = w_allowin;
  assign ib.issue_valid = w_valid;
  assign ib.issue_bus   = w_head_bus;
  assign ib.issue_cnt   = w_iss_num;
  assign ib.issue_int   = has_int & w_valid[0];

  // Entry storage needs no reset: occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < W; k++) begin
        if (ib.in_valid[k])
          r_mem[r_tail + c_PW'(k)] <= ib.in_bus[k*BUS_WD +: BUS_WD];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_PW'(w_iss_num);
      r_tail  <= r_tail + c_PW'(w_wr_add);
      r_count <= r_count + (c_PW+1)'(w_wr_add) - (c_PW+1)'(w_iss_num);
    end
  end

  // Flush cycles are not attributed to any group size or to stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g <= W; g++)
        r_grp_cnt[g] <= '0;
      r_stall_cnt <= '0;
    end else if (!flush) begin
      if (w_iss_num != '0) begin
        r_grp_cnt[w_iss_num] <= r_grp_cnt[w_iss_num] + CNT_WD'(1);
      end else if (r_count != '0) begin
        r_grp_cnt[0] <= r_grp_cnt[0] + CNT_WD'(1);
        r_stall_cnt  <= r_stall_cnt + CNT_WD'(1);
      end
    end
  end

  for (genvar g = 0; g <= W; g++) begin : g_perf
    assign perf_grp_cnt[g*CNT_WD +: CNT_WD] = r_grp_cnt[g];
  end
  assign perf_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/issue_buffer.md
Name: issue_buffer

Overview:
- Parametrised successor to the dual-issue decode/issue front.
- Accepts up to W decoded instructions per cycle into a D-entry circular buffer.
- Issues an in-order group of up to W per cycle to the issue stage. Group size is limited by intra-group hazard and resource rules.
- Supports pipeline flush, tags interrupts on the oldest entry, and keeps per-group-size perf counters.

Parameters:
- W, 2, issue/accept width (2..4)
- D, 8, buffer entries (power of two, D >= 2*W)
- BUS_WD, `DECODE_BUS_WD, width of one decoded entry
- CNT_WD, 32, perf counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  exception/eret flush; empties buffer
- has_int  in  1  interrupt pending from cp0
- in_valid  in  W  decoded slots valid; contiguous from bit 0
- in_bus  in  W*BUS_WD  decoded entries; slot k at [k*BUS_WD +: BUS_WD]
- in_allowin  out  1  free entries >= W
- issue_allowin  in  1  issue stage accepts the whole presented group
- issue_valid  out  W  group slot valid; contiguous from bit 0
- issue_bus  out  W*BUS_WD  oldest-first entries
- issue_int  out  1  interrupt tag, applies to slot 0
- issue_cnt  out  clog2(W+1)  popcount(issue_valid)
- perf_grp_cnt  out  (W+1)*CNT_WD  counter g = cycles in which a g-instruction group issued
- perf_stall_cnt  out  CNT_WD  cycles with buffer non-empty and nothing issued

Behaviour:
- Reset (reset=0, async): head=tail=0, count=0, every perf counter=0. Outputs: issue_valid=0, issue_int=0, in_allowin=1.
- Write: when in_allowin & |in_valid, write popcount(in_valid) entries at tail, then tail += that number mod D. in_valid must be contiguous; non-contiguous input is illegal and the bench asserts on it.
- Buffer-to-issue latency: an entry written in cycle t is presentable at t+1. There is no bypass.
- Group formation is combinational from the head. Slot k (k>=1) is included only if slot k-1 is included, entry k exists, and all rules hold:
  - RAW: rs1 or rs2 of slot k (nonzero reg) equals dest of any earlier slot j<k with gr_we. Match -> cut at k.
  - WAW: dest of slot k equals dest of an earlier gr_we slot -> cut.
  - Resource: at most one complex op (mul/div/mem/cp0/hilo) per group -> cut at the second one.
  - Branch: a branch in slot k is included only if its delay slot (entry k+1) exists and fits in W. Otherwise cut at k. The exception is slot 0, which waits until its delay slot is buffered.
  - Slot 0 carrying eret/cp0 write issues alone.
- Issue: issue_valid is the formed group when issue_allowin=1, else 0. On issue, head += issue_cnt.
- Interrupt tag: issue_int = has_int & issue_valid[0], applied only to slot 0.
- Count: count_next = count + written − issued. A simultaneous write and issue is legal. in_allowin is computed from the registered count, so there is no combinational path from issue_allowin.
- Full: count > D−W forces in_allowin=0 and suppresses the write.
- Empty: issue_valid=0.
- Pointers wrap mod D; count ranges 0..D.
- Flush (sync, highest priority): head=tail=count=0 next cycle. The same cycle's write and issue are discarded. issue_valid must be forced to 0 in the flush cycle.
- Perf counting: a counter increments each issuing cycle for the matching group size g>0. perf_grp_cnt[0] and perf_stall_cnt increment when count>0 and issue_cnt=0. Counters wrap silently. They are not cleared by flush.
- Reset mid-operation: all state cleared immediately; no pending write survives.

Decomposition:
- Shared package/header mycpu.h holds:
  - field offset constants: DS_DEST, DS_GR_WE, DS_RS1, DS_RS2, DS_IS_BR, DS_IS_CPLX, DS_IS_SERIAL
  - `DECODE_BUS_WD
  - `DUAL/`SIGNLE, kept for W=2 compatibility
- One sub-module, issue_group_check: purely combinational, takes W head entries plus availability, returns the group length.

Test Plan (W=2, D=8 unless noted):
- Independent pair: write addu r1 and addu r2 in one cycle, issue_allowin=1. Next cycle issue_valid=2'b11, issue_cnt=2, perf_grp_cnt[2]=1.
- RAW cut: addu r3,r1,r2 then subu r4,r3,r5. Cycle 1 issue_valid=2'b01; cycle 2 subu issues; perf_grp_cnt[1]=2.
- Branch/delay slot: beq at head with delay slot not yet written gives issue_valid=0 and perf_stall_cnt++. Writing the delay slot gives issue_valid=2'b11 the next cycle.
- Full/wrap: hold issue_allowin=0 and write 3 pairs, making count=6 and in_allowin=1. After the 4th pair count=8 and in_allowin=0. Then drain 8 entries; head wraps to 0 with order preserved.
- Flush mid-stream: with count=5, a simultaneous write and flush give count=0, issue_valid=0 and in_allowin=1 next cycle. Perf counters are unchanged.
- Reset and interrupt: has_int=1 with a valid group gives issue_int=1 with slot 0 only. Asserting reset asynchronously mid-cycle drops issue_valid to 0 without waiting for a clock edge.
